// File: rtl/trig_pkg.sv
// Shared defaults and state encoding for the trigger controller slice.
// The optional trigger timestamp is built in when TRIG_TIMESTAMP_EN is defined.
package trig_pkg;

    localparam int TRIG_DWIDTH    = 14;
    localparam int TRIG_HOLDOFF_W = 16;
    localparam int TRIG_CNT_W     = 32;
    localparam int TRIG_TS_W      = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        HOLDOFF = 2'b10
    } trig_state_t;

endpackage

// File: rtl/trig_holdoff.sv
// Loadable down-counter used to time the post-trigger holdoff window.
// Clear has priority over load; the count stops at zero, and zero is flagged.
module trig_holdoff
    import trig_pkg::*;
#(
    parameter int WIDTH = TRIG_HOLDOFF_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Clear aborts, load restarts, enable counts down toward zero and stops there
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/trig_ctrl.sv
// Trigger controller: fires a one-cycle pulse on the false-to-true edge of a
// selectable magnitude compare (A>B, A<B, A=B) against a threshold, latches the
// triggering sample, counts triggers, and holds off before re-arming.
// Define TRIG_TIMESTAMP_EN to add a free-running timestamp and the trig_time port.
module trig_ctrl
    import trig_pkg::*;
#(
    parameter int DWIDTH    = TRIG_DWIDTH,
    parameter int HOLDOFF_W = TRIG_HOLDOFF_W,
    parameter int CNT_W     = TRIG_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DWIDTH-1:0]    adc_data,
    input  logic                 adc_valid,
    input  logic [DWIDTH-1:0]    thresh,
    input  logic                 gt,
    input  logic                 lt,
    input  logic                 et,
    input  logic                 en,
    input  logic [HOLDOFF_W-1:0] holdoff,
    output logic                 trig,
    output logic [DWIDTH-1:0]    trig_data,
    output logic                 busy,
    output logic [CNT_W-1:0]     trig_count
`ifdef TRIG_TIMESTAMP_EN
    ,
    output logic [TRIG_TS_W-1:0] trig_time
`endif
);

    trig_state_t state;
    logic        prev_cond;
    logic        cond;
    logic        fire;
    logic        hold_zero;

    assign cond = (gt && (adc_data > thresh))
               || (et && (adc_data == thresh))
               || (lt && (adc_data < thresh));

    // A fire needs a valid sample whose condition just turned true; dropping en vetoes it
    assign fire = en && (state == ARMED) && adc_valid && cond && !prev_cond;

    trig_holdoff #(
        .WIDTH(HOLDOFF_W)
    ) u_holdoff (
        .clk       (clk),
        .rst       (rst),
        .clear     (!en),
        .load      (fire),
        .load_value(holdoff),
        .en        (state == HOLDOFF),
        .zero      (hold_zero)
    );

    // Arming, firing and holdoff sequencing with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            trig       <= 1'b0;
            trig_data  <= '0;
            busy       <= 1'b0;
            trig_count <= '0;
            prev_cond  <= 1'b1;
        end else begin
            trig <= 1'b0;
            if (!en) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state     <= ARMED;
                        prev_cond <= 1'b1;
                    end
                    ARMED: begin
                        if (adc_valid) begin
                            prev_cond <= cond;
                        end
                        if (fire) begin
                            trig      <= 1'b1;
                            trig_data <= adc_data;
                            if (trig_count != '1) begin
                                trig_count <= trig_count + CNT_W'(1);
                            end
                            state <= HOLDOFF;
                            busy  <= 1'b1;
                        end
                    end
                    HOLDOFF: begin
                        if (hold_zero) begin
                            state     <= ARMED;
                            prev_cond <= 1'b1;
                            busy      <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef TRIG_TIMESTAMP_EN
    logic [TRIG_TS_W-1:0] ts_count;

    // Free-running timestamp, captured alongside the triggering sample
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_count  <= '0;
            trig_time <= '0;
        end else begin
            ts_count <= ts_count + TRIG_TS_W'(1);
            if (fire) begin
                trig_time <= ts_count;
            end
        end
    end
`endif

endmodule

// File: tb/tb_trig_ctrl.sv
// Testbench for trig_ctrl: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model. Builds with or without TRIG_TIMESTAMP_EN.
module tb_trig_ctrl;

    localparam int DW  = 14;
    localparam int HW  = 16;
    localparam int CW  = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] adc_data = '0;
    logic          adc_valid = 1'b0;
    logic [DW-1:0] thresh = '0;
    logic          gt = 1'b0;
    logic          lt = 1'b0;
    logic          et = 1'b0;
    logic          en = 1'b0;
    logic [HW-1:0] holdoff = '0;
    logic          trig;
    logic [DW-1:0] trig_data;
    logic          busy;
    logic [CW-1:0] trig_count;
`ifdef TRIG_TIMESTAMP_EN
    logic [31:0]   trig_time;
`endif

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    bit          m_armed = 0;
    int          m_hold = -1;
    bit          m_prev = 1;
    bit          exp_trig = 0;
    bit          exp_busy = 0;
    logic [DW-1:0] exp_data = '0;
    int          exp_count = 0;
    longint      m_ts = 0;
    logic [31:0] exp_time = '0;

    trig_ctrl #(
        .DWIDTH(DW),
        .HOLDOFF_W(HW),
        .CNT_W(CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .adc_data  (adc_data),
        .adc_valid (adc_valid),
        .thresh    (thresh),
        .gt        (gt),
        .lt        (lt),
        .et        (et),
        .en        (en),
        .holdoff   (holdoff),
        .trig      (trig),
        .trig_data (trig_data),
        .busy      (busy),
        .trig_count(trig_count)
`ifdef TRIG_TIMESTAMP_EN
        ,
        .trig_time (trig_time)
`endif
    );

    always #5 clk = ~clk;

    function automatic bit ref_cond(int a, int b, bit g, bit l, bit e);
        return (g && (a > b)) || (l && (a < b)) || (e && (a == b));
    endfunction

    // Advance the model by one clock using the inputs currently applied
    task automatic model_step();
        bit c;
        exp_trig = 0;
        if (rst) begin
            m_armed = 0; m_hold = -1; m_prev = 1; exp_busy = 0;
            exp_data = '0; exp_count = 0; m_ts = 0; exp_time = '0;
        end else begin
            if (!en) begin
                m_armed = 0; m_hold = -1; exp_busy = 0;
            end else if (m_hold >= 0) begin
                if (m_hold == 0) begin
                    m_hold = -1; m_armed = 1; m_prev = 1; exp_busy = 0;
                end else begin
                    m_hold--;
                end
            end else if (!m_armed) begin
                m_armed = 1; m_prev = 1;
            end else if (adc_valid) begin
                c = ref_cond(int'(adc_data), int'(thresh), gt, lt, et);
                if (c && !m_prev) begin
                    exp_trig = 1;
                    exp_data = adc_data;
                    if (exp_count < CNT_MAX) exp_count++;
                    exp_time = m_ts[31:0];
                    m_hold = int'(holdoff);
                    m_armed = 0;
                    exp_busy = 1;
                end
                m_prev = c;
            end
            m_ts = (m_ts + 1) % (64'd1 << 32);
        end
    endtask

    task automatic applyStimulus(input bit v, input int d);
        adc_valid = v;
        adc_data = d[DW-1:0];
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; en = 0; gt = 0; lt = 0; et = 0; thresh = '0; holdoff = '0;
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        rst = 0;
        checks++; if (trig !== 1'b0) begin failures++; $display("[TB] FAIL reset_trig got %b want 0", trig); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        checks++; if (trig_count !== '0) begin failures++; $display("[TB] FAIL reset_count got %0d want 0", trig_count); end
        checks++; if (trig_data !== '0) begin failures++; $display("[TB] FAIL reset_data got %0d want 0", trig_data); end
`ifdef TRIG_TIMESTAMP_EN
        checks++; if (trig_time !== '0) begin failures++; $display("[TB] FAIL reset_time got %0d want 0", trig_time); end
`endif
    endtask

    task automatic test_gt_crossing();
        int samples[5] = '{50, 99, 100, 101, 150};
        int fires = 0;
        gt = 1; lt = 0; et = 0; thresh = 100; holdoff = 2; en = 1;
        applyStimulus(0, 0);
        foreach (samples[i]) begin
            applyStimulus(1, samples[i]);
            checks++;
            if (trig !== exp_trig) begin failures++; $display("[TB] FAIL gt_trig sample %0d got %b want %b", samples[i], trig, exp_trig); end
            if (trig === 1'b1) begin
                fires++;
                checks++;
                if (samples[i] != 101) begin failures++; $display("[TB] FAIL gt_when fired on sample %0d want 101", samples[i]); end
            end
        end
        checks++; if (fires != 1) begin failures++; $display("[TB] FAIL gt_fires got %0d want 1", fires); end
        checks++; if (trig_data !== 14'd101) begin failures++; $display("[TB] FAIL gt_data got %0d want 101", trig_data); end
        checks++; if (trig_count !== 4'd1) begin failures++; $display("[TB] FAIL gt_count got %0d want 1", trig_count); end
    endtask

    task automatic test_lt_prearmed();
        int samples[4] = '{10, 10, 600, 400};
        en = 0;
        applyStimulus(0, 0);
        gt = 0; lt = 1; et = 0; thresh = 500; en = 1;
        applyStimulus(1, 10);
        foreach (samples[i]) begin
            applyStimulus(1, samples[i]);
            checks++;
            if (trig !== ((i == 3) ? 1'b1 : 1'b0)) begin failures++; $display("[TB] FAIL lt_trig sample %0d got %b want %b", samples[i], trig, (i == 3)); end
        end
        checks++; if (trig_data !== 14'd400) begin failures++; $display("[TB] FAIL lt_data got %0d want 400", trig_data); end
    endtask

    task automatic test_holdoff();
        int first = -1, second = -1, busy_run = 0;
        en = 0;
        applyStimulus(0, 0);
        gt = 1; lt = 0; et = 0; thresh = 0; holdoff = 5; en = 1;
        applyStimulus(0, 0);
        for (int i = 0; i < 30; i++) begin
            holdoff = busy ? 16'd40 : 16'd5;
            applyStimulus(1, i % 2);
            checks++;
            if (trig !== exp_trig || busy !== exp_busy) begin
                failures++; $display("[TB] FAIL hold_cycle %0d got trig=%b busy=%b want trig=%b busy=%b", i, trig, busy, exp_trig, exp_busy);
            end
            if (trig === 1'b1) begin
                if (first < 0) first = i; else if (second < 0) second = i;
            end
            if (first >= 0 && second < 0 && busy === 1'b1) busy_run++;
        end
        holdoff = 5;
        checks++; if (busy_run != 6) begin failures++; $display("[TB] FAIL hold_busy_len got %0d want 6", busy_run); end
        checks++; if (first != 1 || second != 9) begin failures++; $display("[TB] FAIL hold_retrig got %0d,%0d want 1,9", first, second); end
    endtask

    task automatic test_equal_valid();
        en = 0;
        applyStimulus(0, 0);
        gt = 0; lt = 0; et = 1; thresh = 14'h3FFF; holdoff = 0; en = 1;
        applyStimulus(0, 0);
        applyStimulus(1, 0);
        applyStimulus(0, 16'h3FFF);
        checks++; if (trig !== 1'b0) begin failures++; $display("[TB] FAIL eq_invalid got %b want 0", trig); end
        applyStimulus(1, 16'h3FFF);
        checks++; if (trig !== 1'b1) begin failures++; $display("[TB] FAIL eq_valid got %b want 1", trig); end
        checks++; if (trig_data !== 14'h3FFF) begin failures++; $display("[TB] FAIL eq_data got %h want 3fff", trig_data); end
    endtask

    task automatic test_abort_holdoff();
        en = 0;
        applyStimulus(0, 0);
        gt = 1; lt = 0; et = 0; thresh = 100; holdoff = 1000; en = 1;
        applyStimulus(0, 0);
        applyStimulus(1, 0);
        applyStimulus(1, 200);
        checks++; if (trig !== 1'b1) begin failures++; $display("[TB] FAIL abort_fire got %b want 1", trig); end
        for (int i = 0; i < 3; i++) applyStimulus(1, 0);
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL abort_busy got %b want 1", busy); end
        en = 0;
        applyStimulus(1, 0);
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_clear got %b want 0", busy); end
        checks++; if (trig_count !== CW'(exp_count)) begin failures++; $display("[TB] FAIL abort_count got %0d want %0d", trig_count, exp_count); end
        checks++; if (trig_data !== 14'd200) begin failures++; $display("[TB] FAIL abort_data got %0d want 200", trig_data); end
        en = 1;
        applyStimulus(1, 0);
        applyStimulus(1, 0);
        applyStimulus(1, 200);
        checks++; if (trig !== 1'b1) begin failures++; $display("[TB] FAIL abort_rearm got %b want 1", trig); end
        checks++; if (trig_count !== CW'(exp_count)) begin failures++; $display("[TB] FAIL abort_count2 got %0d want %0d", trig_count, exp_count); end
    endtask

    task automatic test_en_fire_same();
        en = 0;
        applyStimulus(0, 0);
        gt = 1; lt = 0; et = 0; thresh = 100; holdoff = 0; en = 1;
        applyStimulus(1, 0);
        applyStimulus(1, 0);
        en = 0;
        applyStimulus(1, 200);
        checks++; if (trig !== 1'b0) begin failures++; $display("[TB] FAIL enfire_trig got %b want 0", trig); end
        checks++; if (trig_count !== CW'(exp_count)) begin failures++; $display("[TB] FAIL enfire_count got %0d want %0d", trig_count, exp_count); end
        en = 1;
    endtask

    task automatic test_reset_mid();
        en = 0;
        applyStimulus(0, 0);
        gt = 1; lt = 0; et = 0; thresh = 100; holdoff = 1000; en = 1;
        applyStimulus(0, 0);
        applyStimulus(1, 0);
        applyStimulus(1, 300);
        applyStimulus(1, 0);
        rst = 1;
        applyStimulus(1, 0);
        rst = 0;
        checks++; if (busy !== 1'b0 || trig !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_flags got busy=%b trig=%b want 0,0", busy, trig); end
        checks++; if (trig_count !== '0 || trig_data !== '0) begin failures++; $display("[TB] FAIL rstmid_regs got count=%0d data=%0d want 0,0", trig_count, trig_data); end
    endtask

`ifdef TRIG_TIMESTAMP_EN
    task automatic test_timestamp();
        rst = 1; en = 1;
        applyStimulus(0, 0);
        rst = 0;
        gt = 1; lt = 0; et = 0; thresh = 100; holdoff = 0;
        applyStimulus(1, 0);
        for (int i = 2; i <= 37; i++) applyStimulus(1, 0);
        applyStimulus(1, 200);
        checks++; if (trig !== 1'b1) begin failures++; $display("[TB] FAIL ts_trig got %b want 1", trig); end
        checks++; if (trig_time !== 32'd37) begin failures++; $display("[TB] FAIL ts_time got %0d want 37", trig_time); end
        checks++; if (trig_time !== exp_time) begin failures++; $display("[TB] FAIL ts_model got %0d want %0d", trig_time, exp_time); end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            en = ($urandom_range(0, 24) != 0);
            gt = 1'($urandom_range(0, 1));
            lt = 1'($urandom_range(0, 1));
            et = 1'($urandom_range(0, 1));
            thresh = 14'($urandom_range(98, 102));
            holdoff = 16'($urandom_range(0, 6));
            applyStimulus($urandom_range(0, 3) != 0, int'($urandom_range(95, 105)));
            checks++;
            if (trig !== exp_trig || busy !== exp_busy || trig_data !== exp_data || trig_count !== CW'(exp_count)) begin
                failures++;
                $display("[TB] FAIL rand_cycle %0d got trig=%b busy=%b data=%0d count=%0d want trig=%b busy=%b data=%0d count=%0d",
                         i, trig, busy, trig_data, trig_count, exp_trig, exp_busy, exp_data, exp_count);
            end
`ifdef TRIG_TIMESTAMP_EN
            checks++;
            if (trig_time !== exp_time) begin failures++; $display("[TB] FAIL rand_time %0d got %0d want %0d", i, trig_time, exp_time); end
`endif
        end
        rst = 0;
    endtask

    task automatic test_saturation();
        int pattern[3] = '{0, 200, 0};
        rst = 1;
        applyStimulus(0, 0);
        rst = 0;
        gt = 1; lt = 0; et = 0; thresh = 100; holdoff = 0; en = 1;
        applyStimulus(0, 0);
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1, pattern[i % 3]);
            checks++;
            if (trig !== exp_trig || trig_count !== CW'(exp_count)) begin
                failures++; $display("[TB] FAIL sat_cycle %0d got trig=%b count=%0d want trig=%b count=%0d", i, trig, trig_count, exp_trig, exp_count);
            end
        end
        checks++; if (trig_count !== 4'hF) begin failures++; $display("[TB] FAIL sat_final got %0d want 15", trig_count); end
    endtask

    initial begin
        test_reset();
        test_gt_crossing();
        test_lt_prearmed();
        test_holdoff();
        test_equal_valid();
        test_abort_holdoff();
        test_en_fire_same();
        test_reset_mid();
`ifdef TRIG_TIMESTAMP_EN
        test_timestamp();
`endif
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
